// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide unit for the Execute stage.
// The result is computed at the start edge and committed to HI/LO after a fixed busy window.
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    logic [0:0]      state_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     hi_q, lo_q, hi_t_q, lo_t_q;
    logic            skip_q;

    logic [63:0] a_sx, b_sx, prod_s, prod_u;
    logic [31:0] a_mag, b_mag, divisor_u, divisor_s;
    logic [31:0] uq, ur, mq, mr, sq, sr;
    logic [31:0] res_hi, res_lo;
    logic        is_start, is_div;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    assign a_mag     = A[31] ? (32'd0 - A) : A;
    assign b_mag     = B[31] ? (32'd0 - B) : B;
    assign divisor_u = (B == 32'd0) ? 32'd1 : B;
    assign divisor_s = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign uq        = A / divisor_u;
    assign ur        = A % divisor_u;
    assign mq        = a_mag / divisor_s;
    assign mr        = a_mag % divisor_s;
    assign sq        = (A[31] ^ B[31]) ? (32'd0 - mq) : mq;
    assign sr        = A[31] ? (32'd0 - mr) : mr;

    assign is_start = start && (MDUOp >= OpMult) && (MDUOp <= OpDivu);
    assign is_div   = (MDUOp == OpDiv) || (MDUOp == OpDivu);

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDUOp)
            OpMult:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
            OpMultu: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
            OpDiv:   begin res_hi = sr;            res_lo = sq;           end
            OpDivu:  begin res_hi = ur;            res_lo = uq;           end
            default: begin res_hi = 32'd0;         res_lo = 32'd0;        end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_t_q  <= 32'd0;
            lo_t_q  <= 32'd0;
            skip_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (is_start) begin
                        hi_t_q  <= res_hi;
                        lo_t_q  <= res_lo;
                        skip_q  <= is_div && (B == 32'd0);
                        cnt_q   <= is_div ? DivLoad : MultLoad;
                        state_q <= StRun;
                    end else if (MDUOp == OpMthi) begin
                        hi_q <= A;
                    end else if (MDUOp == OpMtlo) begin
                        lo_q <= A;
                    end
                end
                StRun: begin
                    cnt_q <= cnt_q - CntOne;
                    if (cnt_q == CntOne) begin
                        state_q <= StIdle;
                        // Divide by zero still occupies the unit but leaves HI/LO untouched.
                        if (!skip_q) begin
                            hi_q <= hi_t_q;
                            lo_q <= lo_t_q;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign Busy = (state_q == StRun);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: stimulus pushes expected commits, a monitor pops them
// whenever Busy falls.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  MDUOp;
    logic        start;
    logic        Busy;
    logic [31:0] HI, LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cur_hi, cur_lo;

    always #5 clk = ~clk;

    mdu_sequencer #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .A    (A),
        .B    (B),
        .MDUOp(MDUOp),
        .start(start),
        .Busy (Busy),
        .HI   (HI),
        .LO   (LO)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        int   busy_cnt;
        logic busy_prev;
        exp_t e;
        busy_cnt  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (Busy === 1'b1) begin
                busy_cnt++;
            end else if (busy_prev) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got busy fall expected none");
                end else begin
                    e = sb.pop_front();
                    chk("commit_hi", HI, e.hi);
                    chk("commit_lo", LO, e.lo);
                    chk("busy_len", 32'(busy_cnt), 32'(e.len));
                end
                busy_cnt = 0;
            end
            busy_prev = (Busy === 1'b1);
        end
    end

    // inject: 0 none, 1 start+mult then mtlo during RUN, 2 reset at busy cycle 4.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int n,
                         input int inject, input string tag);
        exp_t e;
        A     = a;
        B     = b;
        MDUOp = op;
        start = 1'b1;
        e.hi  = (inject == 2) ? 32'd0 : exp_hi;
        e.lo  = (inject == 2) ? 32'd0 : exp_lo;
        e.len = (inject == 2) ? 4 : n;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        MDUOp = 3'd0;
        A     = 32'h5A5A5A5A;
        B     = 32'd0;
        for (int i = 1; i <= n; i++) begin
            if (inject == 1 && i == 3) begin
                start = 1'b1;
                MDUOp = 3'd1;
                A     = 32'd3;
                B     = 32'd3;
            end
            if (inject == 1 && i == 4) begin
                MDUOp = 3'd6;
                A     = 32'h0000AAAA;
            end
            if (inject == 2 && i == 4) reset = 1'b1;
            @(negedge clk);
            chk({tag, "_busy"}, {31'd0, Busy}, 32'd1);
            chk({tag, "_hold_hi"}, HI, cur_hi);
            chk({tag, "_hold_lo"}, LO, cur_lo);
            @(posedge clk);
            #1;
            start = 1'b0;
            MDUOp = 3'd0;
            A     = 32'h5A5A5A5A;
            reset = 1'b0;
            if (inject == 2 && i == 4) break;
        end
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    task automatic do_mt(input logic [2:0] op, input logic [31:0] val, input string tag);
        MDUOp = op;
        A     = val;
        @(posedge clk);
        #1;
        MDUOp = 3'd0;
        A     = 32'h5A5A5A5A;
        if (op == 3'd5) cur_hi = val;
        else cur_lo = val;
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_hi"}, HI, cur_hi);
        chk({tag, "_lo"}, LO, cur_lo);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        MDUOp  = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
        cur_hi = 32'd0;
        cur_lo = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        do_op(3'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0, "mult");
        do_op(3'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5, 0, "multu");
        do_op(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 0, "div");
        do_op(3'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0, "divu");
        do_mt(3'd5, 32'h12345678, "mthi");
        do_op(3'd3, 32'd5, 32'd0, 32'h12345678, 32'd3, 10, 0, "div0");
        do_op(3'd4, 32'd9, 32'd0, 32'h12345678, 32'd3, 10, 0, "divu0");
        do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10, 0, "div_ovf");
        do_op(3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, 0, "div_negb");
        do_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10, 1, "div_ign");
        do_op(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5, 0, "mult_b2b");
        do_mt(3'd6, 32'h0000AAAA, "mtlo");

        MDUOp = 3'd7;
        start = 1'b1;
        A     = 32'd1;
        B     = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDUOp = 3'd0;
        @(negedge clk);
        chk("reserved_busy", {31'd0, Busy}, 32'd0);
        chk("reserved_hi", HI, cur_hi);
        chk("reserved_lo", LO, cur_lo);

        do_op(3'd3, 32'd20, 32'd3, 32'd0, 32'd0, 10, 2, "div_rst");
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("post_rst_busy", {31'd0, Busy}, 32'd0);
        chk("post_rst_hi", HI, 32'd0);
        chk("post_rst_lo", LO, 32'd0);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
